// File: rtl/div_unsigned_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A zero divisor is resolved immediately in IDLE (q all ones, r = a, dbz set).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; zero-divisor requests are answered here
// CALC  | WIDTH restoring steps; the final step publishes q/r/done
module div_unsigned_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign busy = (state == CALC);

  // One restoring step: shift {rem, quo} left, trial-subtract, keep or restore.
  always_comb begin
    shifted = {rem, quo} << 1;
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, dvsr};
    rem_nxt = shifted[2*WIDTH:WIDTH];
    quo_nxt = shifted[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      rem_nxt    = trial;
      quo_nxt[0] = 1'b1;
    end
  end

  // Control FSM with registered results; done defaults low so it is a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b != '0) begin
              quo   <= a;
              dvsr  <= b;
              rem   <= '0;
              cnt   <= '0;
              state <= CALC;
            end else begin
              q    <= '1;
              r    <= a;
              dbz  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        CALC: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            q     <= quo_nxt;
            r     <= rem_nxt[WIDTH-1:0];
            dbz   <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unsigned_seq.sv
// Self-checking bench for div_unsigned_seq (WIDTH = 8).
module tb_div_unsigned_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] q, r;

  int checks = 0;
  int errors = 0;

  div_unsigned_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           edges;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor rule.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] mq, output logic [W-1:0] mr,
                       output logic mdbz);
    if (mb == 0) begin
      mq = '1; mr = ma; mdbz = 1'b1;
    end else begin
      mq = ma / mb; mr = ma % mb; mdbz = 1'b0;
    end
  endtask

  // Issue one division from a negedge; report result, edges from the
  // accepting edge to the edge that raised done, and protocol sanity.
  task automatic do_div(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] oq, output logic [W-1:0] or_,
                        output logic odbz, output int edges,
                        output bit busy_ok, output bit hold_ok);
    logic [W-1:0] q0, r0;
    q0 = q; r0 = r;
    busy_ok = 1'b1; hold_ok = 1'b1; edges = 0;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (q != q0 || r != r0) hold_ok = 1'b0;
      if (edges > 40) break;
      @(posedge clk);
      edges++;
    end
    if (busy) busy_ok = 1'b0;
    oq = q; or_ = r; odbz = dbz;
  endtask

  initial begin
    logic [W-1:0] gq, gr, eq, er;
    logic         gd, ed;
    int           ed_cnt, n, m;
    bit           bok, hok;

    vecs[0] = '{8'd127, 8'd10,  8'd12,  8'd7,   1'b0, 8};
    vecs[1] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
    vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[3] = '{8'd5,   8'd10,  8'd0,   8'd5,   1'b0, 8};
    vecs[4] = '{8'd0,   8'd7,   8'd0,   8'd0,   1'b0, 8};
    vecs[5] = '{8'd123, 8'd231, 8'd0,   8'd123, 1'b0, 8};
    vecs[6] = '{8'd244, 8'd0,   8'd255, 8'd244, 1'b1, 0};
    vecs[7] = '{8'd23,  8'd1,   8'd23,  8'd0,   1'b0, 8};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset q", q, 0);
    check("reset r", r, 0);
    check("reset dbz", dbz, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_div(vecs[i].a, vecs[i].b, gq, gr, gd, n, bok, hok);
      check($sformatf("vec%0d q", i), gq, vecs[i].q);
      check($sformatf("vec%0d r", i), gr, vecs[i].r);
      check($sformatf("vec%0d dbz", i), gd, vecs[i].dbz);
      check($sformatf("vec%0d latency", i), n, vecs[i].edges);
      check($sformatf("vec%0d busy", i), bok, 1);
      check($sformatf("vec%0d hold", i), hok, 1);
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), done, 0);
    end

    // Start while busy is ignored
    a = 8'd100; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd50; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("ignore q", q, 14);
    check("ignore r", r, 2);
    ed_cnt = 0;
    repeat (12) begin @(negedge clk); if (done) ed_cnt++; end
    check("ignore no extra done", ed_cnt, 0);

    // Start held high through done: back-to-back, 9 cycles apart
    a = 8'd127; b = 8'd10; start = 1'b1;
    n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (!done && n < 40);
    check("b2b first edges", n, 9);
    m = 0;
    do begin @(posedge clk); @(negedge clk); m++; end while (!done && m < 40);
    start = 1'b0;
    check("b2b spacing", m, 9);
    check("b2b q", q, 12);
    check("b2b r", r, 7);
    @(negedge clk);
    check("b2b busy after", busy, 0);

    // Consecutive zero-divisor starts keep done high with fresh data
    a = 8'd9; b = 8'd0; start = 1'b1;
    @(negedge clk);
    check("dz1 done", done, 1);
    check("dz1 r", r, 9);
    a = 8'd11;
    @(negedge clk);
    start = 1'b0;
    check("dz2 done", done, 1);
    check("dz2 r", r, 11);
    check("dz2 busy", busy, 0);
    @(negedge clk);
    check("dz done drops", done, 0);

    // Reset mid-operation
    a = 8'd200; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid busy before rst", busy, 1);
    rst = 1'b1;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst q", q, 0);
    check("rst r", r, 0);
    check("rst dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b0;
    ed_cnt = 0;
    repeat (12) begin @(negedge clk); if (done || busy) ed_cnt++; end
    check("rst no done", ed_cnt, 0);
    do_div(8'd200, 8'd3, gq, gr, gd, n, bok, hok);
    check("after rst q", gq, 66);
    check("after rst r", gr, 2);
    check("after rst latency", n, 8);

    // Random regression against the arithmetic reference
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 99) < 5) ? '0 : W'($urandom_range(1, 255));
      model(ra, rb, eq, er, ed);
      do_div(ra, rb, gq, gr, gd, n, bok, hok);
      if (gq != eq || gr != er || gd != ed) begin
        checks++; errors++;
        $display("FAIL rand %0d/%0d: got q=%0d r=%0d dbz=%0d expected q=%0d r=%0d dbz=%0d",
                 ra, rb, gq, gr, gd, eq, er, ed);
      end else checks++;
      if (rb != 0) begin
        check("rand identity", longint'(gq) * rb + gr, ra);
        check("rand r<b", (gr < rb), 1);
      end
      check("rand latency", n, (rb == 0) ? 0 : 8);
      check("rand busy", bok, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
